// File: rtl/mem_copy_dma_if.sv
// Byte-wide memory bus shared by the copy engine (CONSUMER) and a memory
// responder (PROVIDER).
interface memory_bus;
  logic [31:0] addr;
  logic [7:0]  write_data;
  logic        dispatch_read;
  logic        dispatch_write;
  logic [7:0]  read_data;
  logic        finished_op;

  modport CONSUMER (
    output addr,
    output write_data,
    output dispatch_read,
    output dispatch_write,
    input  read_data,
    input  finished_op
  );

  modport PROVIDER (
    input  addr,
    input  write_data,
    input  dispatch_read,
    input  dispatch_write,
    output read_data,
    output finished_op
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Byte-at-a-time memory copy engine on memory_bus; define MEM_COPY_DMA_FILL_EN
// to add a fill mode that writes a constant byte without reading.
module mem_copy_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [31:0]      src_addr_in,
  input  logic [31:0]      dst_addr_in,
  input  logic [LEN_W-1:0] length_in,
`ifdef MEM_COPY_DMA_FILL_EN
  input  logic             fill_in,
  input  logic [7:0]       fill_value_in,
`endif
  output logic             busy_out,
  output logic             done_out,
  output logic [2:0]       dbg_state_out,
  memory_bus.CONSUMER      mem_bus
);

  // Handshake: dispatch_read/dispatch_write is a one-cycle request carrying
  // addr (and write_data); exactly one operation is outstanding until the
  // responder pulses finished_op, which is only honoured in RD_WAIT/WR_WAIT.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_cnt;
  logic             r_fill;
  logic [7:0]       r_fill_val;
  logic             r_done;
  logic             w_fill_req;
  logic [7:0]       w_fill_byte;
  logic [31:0]      w_src_nxt;
  logic [31:0]      w_dst_nxt;

`ifdef MEM_COPY_DMA_FILL_EN
  assign w_fill_req  = fill_in;
  assign w_fill_byte = fill_value_in;
`else
  assign w_fill_req  = 1'b0;
  assign w_fill_byte = 8'h00;
`endif

  assign w_src_nxt     = r_src + 32'd1;
  assign w_dst_nxt     = r_dst + 32'd1;
  assign busy_out      = (r_state != IDLE);
  assign done_out      = r_done;
  assign dbg_state_out = r_state;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state                <= IDLE;
      r_src                  <= '0;
      r_dst                  <= '0;
      r_cnt                  <= '0;
      r_fill                 <= 1'b0;
      r_fill_val             <= '0;
      r_done                 <= 1'b0;
      mem_bus.addr           <= '0;
      mem_bus.write_data     <= '0;
      mem_bus.dispatch_read  <= 1'b0;
      mem_bus.dispatch_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_in) begin
            if (length_in == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_src      <= src_addr_in;
              r_dst      <= dst_addr_in;
              r_cnt      <= length_in;
              r_fill     <= w_fill_req;
              r_fill_val <= w_fill_byte;
              if (w_fill_req) begin
                r_state                <= WR_REQ;
                mem_bus.addr           <= dst_addr_in;
                mem_bus.write_data     <= w_fill_byte;
                mem_bus.dispatch_write <= 1'b1;
              end else begin
                r_state               <= RD_REQ;
                mem_bus.addr          <= src_addr_in;
                mem_bus.dispatch_read <= 1'b1;
              end
            end
          end
        end
        RD_REQ: begin
          mem_bus.dispatch_read <= 1'b0;
          r_state               <= RD_WAIT;
        end
        RD_WAIT: begin
          // write_data doubles as the captured byte register.
          if (mem_bus.finished_op) begin
            r_state                <= WR_REQ;
            mem_bus.addr           <= r_dst;
            mem_bus.write_data     <= mem_bus.read_data;
            mem_bus.dispatch_write <= 1'b1;
          end
        end
        WR_REQ: begin
          mem_bus.dispatch_write <= 1'b0;
          r_state                <= WR_WAIT;
        end
        WR_WAIT: begin
          if (mem_bus.finished_op) begin
            r_src <= w_src_nxt;
            r_dst <= w_dst_nxt;
            r_cnt <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (r_fill) begin
              r_state                <= WR_REQ;
              mem_bus.addr           <= w_dst_nxt;
              mem_bus.write_data     <= r_fill_val;
              mem_bus.dispatch_write <= 1'b1;
            end else begin
              r_state               <= RD_REQ;
              mem_bus.addr          <= w_src_nxt;
              mem_bus.dispatch_read <= 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: latency-programmable responder, bus
// transaction log compared against hand-computed expected queues.
module tb_mem_copy_dma;
  logic        clk;
  logic        rst_in;
  logic        start_in;
  logic [31:0] src_addr_in;
  logic [31:0] dst_addr_in;
  logic [15:0] length_in;
  logic        busy_out;
  logic        done_out;
  logic [2:0]  dbg_state_out;
`ifdef MEM_COPY_DMA_FILL_EN
  logic        fill_in;
  logic [7:0]  fill_value_in;
`endif

  memory_bus bus ();

  mem_copy_dma #(.LEN_W(16)) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .src_addr_in   (src_addr_in),
    .dst_addr_in   (dst_addr_in),
    .length_in     (length_in),
`ifdef MEM_COPY_DMA_FILL_EN
    .fill_in       (fill_in),
    .fill_value_in (fill_value_in),
`endif
    .busy_out      (busy_out),
    .done_out      (done_out),
    .dbg_state_out (dbg_state_out),
    .mem_bus       (bus.CONSUMER)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int proto_err = 0;
  int done_cnt = 0;
  int resp_lat = 2;
  bit prev_done = 1'b0;
  bit pending = 1'b0;
  bit pend_rd = 1'b0;
  int wcnt = 0;
  logic [31:0] pend_addr;
  // log entry: {is_write, addr, data}
  logic [40:0] act_q[$];
  logic [40:0] exp_q[$];

  // Responder + monitor. Read data = addr[7:0] ^ 8'hA5.
  always @(negedge clk) begin
    bus.finished_op = 1'b0;
    bus.read_data   = 8'h00;
    if (pending) begin
      if (wcnt == 0) begin
        bus.finished_op = 1'b1;
        if (pend_rd) bus.read_data = pend_addr[7:0] ^ 8'hA5;
        pending = 1'b0;
      end else begin
        wcnt = wcnt - 1;
      end
    end
    if (bus.dispatch_read === 1'b1 && bus.dispatch_write === 1'b1) proto_err++;
    if (bus.dispatch_read === 1'b1 || bus.dispatch_write === 1'b1) begin
      if (pending) proto_err++;
      pending   = 1'b1;
      pend_rd   = bus.dispatch_read;
      pend_addr = bus.addr;
      wcnt      = resp_lat - 1;
      if (bus.dispatch_read === 1'b1) act_q.push_back({1'b0, bus.addr, 8'h00});
      else act_q.push_back({1'b1, bus.addr, bus.write_data});
    end
    if (done_out === 1'b1) begin
      done_cnt++;
      if (prev_done) proto_err++;
    end
    prev_done = (done_out === 1'b1);
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic f, input logic [7:0] fv);
    src_addr_in = s;
    dst_addr_in = d;
    length_in   = l;
`ifdef MEM_COPY_DMA_FILL_EN
    fill_in       = f;
    fill_value_in = fv;
`else
    if (f) $display("note: fill requested in a build without fill mode (value %h)", fv);
`endif
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int c0;
    c0 = done_cnt;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (done_cnt > c0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    start_in = 1'b0;
    src_addr_in = '0;
    dst_addr_in = '0;
    length_in = '0;
`ifdef MEM_COPY_DMA_FILL_EN
    fill_in = 1'b0;
    fill_value_in = 8'h00;
`endif
    repeat (3) tick();
    n_checks++; if (busy_out !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    n_checks++; if (done_out !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done_out); end
    n_checks++; if (bus.dispatch_read !== 1'b0) begin n_errors++; $display("FAIL reset_drd: got %b want 0", bus.dispatch_read); end
    n_checks++; if (bus.dispatch_write !== 1'b0) begin n_errors++; $display("FAIL reset_dwr: got %b want 0", bus.dispatch_write); end
    n_checks++; if (bus.addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", bus.addr); end
    n_checks++; if (bus.write_data !== 8'h00) begin n_errors++; $display("FAIL reset_wdata: got %h want 0", bus.write_data); end
    n_checks++; if (dbg_state_out !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", dbg_state_out); end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_copy3();
    bit ok;
    act_q.delete(); exp_q.delete(); done_cnt = 0; resp_lat = 2;
    exp_q = '{{1'b0, 32'h100, 8'h00}, {1'b1, 32'h200, 8'hA5},
              {1'b0, 32'h101, 8'h00}, {1'b1, 32'h201, 8'hA4},
              {1'b0, 32'h102, 8'h00}, {1'b1, 32'h202, 8'hA7}};
    do_start(32'h100, 32'h200, 16'd3, 1'b0, 8'h00);
    n_checks++; if (busy_out !== 1'b1) begin n_errors++; $display("FAIL copy3_busy: got %b want 1", busy_out); end
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL copy3_timeout: got no done want done"); end
    n_checks++; if (act_q.size() != exp_q.size()) begin n_errors++; $display("FAIL copy3_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL copy3_txn[%0d]: got %h want %h", i, (i < act_q.size()) ? act_q[i] : 41'h0, exp_q[i]);
      end
    end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL copy3_done_cnt: got %0d want 1", done_cnt); end
    n_checks++; if (busy_out !== 1'b0) begin n_errors++; $display("FAIL copy3_idle: got %b want 0", busy_out); end
  endtask

  task automatic test_len0();
    act_q.delete(); done_cnt = 0;
    src_addr_in = 32'h1234; dst_addr_in = 32'h5678; length_in = 16'd0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    n_checks++; if (done_out !== 1'b1) begin n_errors++; $display("FAIL len0_done: got %b want 1", done_out); end
    n_checks++; if (busy_out !== 1'b1) begin n_errors++; $display("FAIL len0_busy: got %b want 1", busy_out); end
    tick();
    n_checks++; if (done_out !== 1'b0) begin n_errors++; $display("FAIL len0_done_clr: got %b want 0", done_out); end
    n_checks++; if (busy_out !== 1'b0) begin n_errors++; $display("FAIL len0_idle: got %b want 0", busy_out); end
    repeat (3) tick();
    n_checks++; if (act_q.size() != 0) begin n_errors++; $display("FAIL len0_traffic: got %0d want 0", act_q.size()); end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL len0_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    bit ok;
    act_q.delete(); exp_q.delete(); done_cnt = 0; resp_lat = 3;
    exp_q = '{{1'b0, 32'hFFFF_FFFF, 8'h00}, {1'b1, 32'h10, 8'h5A},
              {1'b0, 32'h0000_0000, 8'h00}, {1'b1, 32'h11, 8'hA5}};
    do_start(32'hFFFF_FFFF, 32'h10, 16'd2, 1'b0, 8'h00);
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL wrap_timeout: got no done want done"); end
    n_checks++; if (act_q.size() != exp_q.size()) begin n_errors++; $display("FAIL wrap_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL wrap_txn[%0d]: got %h want %h", i, (i < act_q.size()) ? act_q[i] : 41'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    act_q.delete(); exp_q.delete(); done_cnt = 0; resp_lat = 4;
    exp_q = '{{1'b0, 32'h300, 8'h00}, {1'b1, 32'h400, 8'hA5},
              {1'b0, 32'h301, 8'h00}, {1'b1, 32'h401, 8'hA4}};
    do_start(32'h300, 32'h400, 16'd2, 1'b0, 8'h00);
    for (int k = 0; k < 50 && act_q.size() < 1; k++) tick();
    tick();
    n_checks++; if (dbg_state_out !== 3'd2) begin n_errors++; $display("FAIL ign_state: got %0d want 2", dbg_state_out); end
    do_start(32'h900, 32'h990, 16'd5, 1'b0, 8'h00);
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL ign_timeout: got no done want done"); end
    repeat (5) tick();
    n_checks++; if (act_q.size() != exp_q.size()) begin n_errors++; $display("FAIL ign_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL ign_txn[%0d]: got %h want %h", i, (i < act_q.size()) ? act_q[i] : 41'h0, exp_q[i]);
      end
    end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    act_q.delete(); done_cnt = 0; resp_lat = 8;
    do_start(32'h500, 32'h600, 16'd2, 1'b0, 8'h00);
    for (int k = 0; k < 60 && act_q.size() < 2; k++) tick();
    tick(); tick();
    n_checks++; if (dbg_state_out !== 3'd4) begin n_errors++; $display("FAIL rstmid_pre_state: got %0d want 4", dbg_state_out); end
    rst_in = 1'b0;
    #1;
    n_checks++; if (busy_out !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy_out); end
    n_checks++; if (bus.addr !== 32'h0 || bus.write_data !== 8'h00) begin n_errors++; $display("FAIL rstmid_bus: got %h/%h want 0/0", bus.addr, bus.write_data); end
    n_checks++; if (bus.dispatch_read !== 1'b0 || bus.dispatch_write !== 1'b0 || done_out !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_ctl: got %b%b%b want 000", bus.dispatch_read, bus.dispatch_write, done_out);
    end
    tick();
    rst_in = 1'b1;
    act_q.delete();
    repeat (20) tick();
    n_checks++; if (act_q.size() != 0) begin n_errors++; $display("FAIL rstmid_traffic: got %0d want 0", act_q.size()); end
    n_checks++; if (busy_out !== 1'b0 || done_cnt != 0) begin n_errors++; $display("FAIL rstmid_idle: got busy=%b done_cnt=%0d want 0/0", busy_out, done_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    act_q.delete(); exp_q.delete(); done_cnt = 0; resp_lat = 1;
    exp_q = '{{1'b0, 32'h55, 8'h00}, {1'b1, 32'h66, 8'hF0},
              {1'b0, 32'h07, 8'h00}, {1'b1, 32'h08, 8'hA2}};
    do_start(32'h55, 32'h66, 16'd1, 1'b0, 8'h00);
    wait_done(ok1);
    do_start(32'h07, 32'h08, 16'd1, 1'b0, 8'h00);
    wait_done(ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_errors++; $display("FAIL b2b_timeout: got %b%b want 11", ok1, ok2); end
    n_checks++; if (act_q.size() != exp_q.size()) begin n_errors++; $display("FAIL b2b_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL b2b_txn[%0d]: got %h want %h", i, (i < act_q.size()) ? act_q[i] : 41'h0, exp_q[i]);
      end
    end
    n_checks++; if (done_cnt != 2) begin n_errors++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
  endtask

`ifdef MEM_COPY_DMA_FILL_EN
  task automatic test_fill();
    bit ok;
    act_q.delete(); exp_q.delete(); done_cnt = 0; resp_lat = 2;
    exp_q = '{{1'b1, 32'h40, 8'hAB}, {1'b1, 32'h41, 8'hAB},
              {1'b1, 32'h42, 8'hAB}, {1'b1, 32'h43, 8'hAB}};
    do_start(32'h999, 32'h40, 16'd4, 1'b1, 8'hAB);
    fill_in = 1'b0;
    wait_done(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL fill_timeout: got no done want done"); end
    n_checks++; if (act_q.size() != exp_q.size()) begin n_errors++; $display("FAIL fill_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL fill_txn[%0d]: got %h want %h", i, (i < act_q.size()) ? act_q[i] : 41'h0, exp_q[i]);
      end
    end
  endtask
`endif

  task automatic test_protocol();
    n_checks++; if (proto_err != 0) begin n_errors++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_copy3();
    test_len0();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_COPY_DMA_FILL_EN
    test_fill();
`endif
    test_protocol();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
